timestamp_arbiter: RTL and testbench
====================================

TIMESTAMP_ARBITER -- requirements
Module: timestamp_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, giving the number of requesting timestamp FIFO sources (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, giving the stall-release limit in cycles (1..65535); used only under REQ-030.
REQ-003 SHALL have port BUS_CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port BUS_RST, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ENABLE_MASK, input, N bits: a 1 allows that source to win arbitration.
REQ-006 SHALL have port IN_EMPTY, input, N bits: source FIFO empty flags.
REQ-007 SHALL have port IN_DATA, input, 32*N bits: source i occupies bits [32i+31:32i]; first-word-fall-through, so data is valid whenever the source is not empty.
REQ-008 SHALL have port IN_READ, output, N bits: pop strobe per source, at most one bit high per cycle.
REQ-009 SHALL have port OUT_FULL, input, 1 bit: downstream FIFO full, with at least one entry of slack after assertion.
REQ-010 SHALL have port OUT_WRITE, output, 1 bit: downstream write strobe, registered.
REQ-011 SHALL have port OUT_DATA, output, 32 bits: downstream word, registered.
REQ-012 SHALL have port GRANT_ID, output, 3 bits: index of the currently or last granted source.
REQ-013 SHALL have port BUSY, output, 1 bit: high while in state LOCK.
REQ-014 SHALL have port TIMEOUT_CNT, output, 8 bits: saturating count of timeout releases.

Function
REQ-015 SHALL implement a two-state FSM with states IDLE and LOCK.
REQ-016 In IDLE, eligible sources (ENABLE_MASK[i] and !IN_EMPTY[i]) SHALL be searched round-robin, starting at (last_grant+1) mod N; on a hit, GRANT_ID and last_grant take the winner and the FSM enters LOCK on the next cycle.
REQ-017 IDLE SHALL never assert IN_READ, so every grant change costs exactly one idle cycle.
REQ-018 In LOCK, IN_READ[GRANT_ID] SHALL equal !IN_EMPTY[GRANT_ID] & !OUT_FULL, combinationally.
REQ-019 Each pop SHALL produce OUT_WRITE=1 with OUT_DATA equal to the popped word in the following cycle (latency 1); OUT_WRITE=0 in every other cycle, and OUT_DATA holds its last value.
REQ-020 Frame rule: a popped word with bits[27:24]==4'h1 keeps the lock; any other value ends the frame.
REQ-021 The cycle after a frame-ending pop, the FSM SHALL be in IDLE.
REQ-022 A two-word timestamp (type 1 then type 2) SHALL never be interleaved with words from another source.
REQ-023 Deasserting ENABLE_MASK for the granted source during LOCK SHALL NOT break the frame; the mask is only consulted in IDLE.
REQ-024 OUT_FULL asserted in LOCK SHALL stall popping without leaving LOCK; popping resumes in the first cycle OUT_FULL is low.
REQ-025 With all sources masked or empty, the block SHALL stay in IDLE with IN_READ=0.
REQ-026 A source that goes empty mid-frame SHALL hold the lock, subject to REQ-030.
REQ-027 Sources with a simultaneous first request SHALL be served in round-robin order, so no enabled, non-empty source waits more than N-1 frames.

Reset
REQ-028 While BUS_RST is high at a clock edge, the following SHALL be cleared:
- FSM to IDLE; last_grant to N-1, so the first search starts at source 0.
- GRANT_ID, TIMEOUT_CNT, OUT_DATA and OUT_WRITE to 0; timeout counter to 0.
- IN_READ forced to 0 combinationally.
REQ-029 A reset mid-frame SHALL abandon the frame; any registered write pending is dropped (OUT_WRITE=0 in the following cycle).

Configuration
REQ-030 With macro TIMESTAMP_ARBITER_TIMEOUT_EN defined:
- A 16-bit counter increments each LOCK cycle in which the granted source is empty, and clears on any pop.
- On reaching TIMEOUT, the FSM returns to IDLE the next cycle and TIMEOUT_CNT increments, saturating at 255.
REQ-031 Without the macro, no timeout logic SHALL be built, LOCK waits indefinitely, and TIMEOUT_CNT is tied to 0.

Verification
REQ-032 Source 0 holds 0x11000001 and 0x12000002, OUT_FULL=0 -> IN_READ[0] in 2 consecutive cycles; OUT_WRITE with both words in that order, each 1 cycle after its pop; IDLE afterwards.
REQ-033 Sources 0-3 each hold one two-word frame, all requesting at once after reset -> output order is frames 0,1,2,3, each contiguous, with one idle cycle between frames.
REQ-034 Source 1 pops 0x11000005 and then goes empty, while source 2 requests -> source 2 is not served until source 1 supplies 0x12000006.
REQ-035 OUT_FULL held high for 10 cycles mid-frame -> no IN_READ during those cycles, BUSY stays 1, and the frame completes after release.
REQ-036 With TIMESTAMP_ARBITER_TIMEOUT_EN and TIMEOUT=4, source 0 stalls after a type-1 word -> IDLE after 4 empty cycles, TIMEOUT_CNT=1, source 1 granted next.
REQ-037 BUS_RST pulsed the cycle after a pop -> OUT_WRITE=0 and GRANT_ID=0 the next cycle, and arbitration restarts at source 0.

Source files
------------

// File: rtl/timestamp_arbiter.sv
// Round-robin arbiter merging N first-word-fall-through timestamp FIFOs into one stream, keeping multi-word frames contiguous.
// Optional stall-release timeout is built only when TIMESTAMP_ARBITER_TIMEOUT_EN is defined.
module timestamp_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            BUS_CLK,
    input  logic            BUS_RST,
    input  logic [N-1:0]    ENABLE_MASK,
    input  logic [N-1:0]    IN_EMPTY,
    input  logic [32*N-1:0] IN_DATA,
    output logic [N-1:0]    IN_READ,
    input  logic            OUT_FULL,
    output logic            OUT_WRITE,
    output logic [31:0]     OUT_DATA,
    output logic [2:0]      GRANT_ID,
    output logic            BUSY,
    output logic [7:0]      TIMEOUT_CNT
);

    if (N < 2 || N > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("timestamp_arbiter: parameter out of range");
    end

    typedef enum logic {IDLE, LOCK} state_t;

    state_t      state;
    logic [2:0]  last_grant;
    logic [2:0]  grant_id;
    logic        out_write;
    logic [31:0] out_data;

    logic [31:0] sel_data;
    logic        sel_empty;
    logic        pop;
    logic        hit;
    logic [2:0]  winner;
    logic [N-1:0] elig;
    logic        timeout_hit;

    always_comb begin
        sel_data  = '0;
        sel_empty = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_id == 3'(i)) begin
                sel_data  = IN_DATA[32*i +: 32];
                sel_empty = IN_EMPTY[i];
            end
        end
    end

    assign pop = (state == LOCK) && !BUS_RST && !sel_empty && !OUT_FULL;

    always_comb begin
        IN_READ = '0;
        for (int unsigned i = 0; i < N; i++) begin
            IN_READ[i] = pop && (grant_id == 3'(i));
        end
    end

    assign elig = ENABLE_MASK & ~IN_EMPTY;

    // Search order starts one past the last winner and wraps, giving round-robin fairness.
    always_comb begin
        hit    = 1'b0;
        winner = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!hit && elig[i] && (i == (32'(last_grant) + k) % N)) begin
                    hit    = 1'b1;
                    winner = 3'(i);
                end
            end
        end
    end

`ifdef TIMESTAMP_ARBITER_TIMEOUT_EN
    logic [15:0] stall_cnt;
    logic [7:0]  timeout_cnt;

    assign timeout_hit = (state == LOCK) && sel_empty && ((32'(stall_cnt) + 32'd1) >= TIMEOUT);

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            stall_cnt   <= '0;
            timeout_cnt <= '0;
        end else if (state != LOCK || pop) begin
            stall_cnt <= '0;
        end else if (sel_empty) begin
            if (timeout_hit) begin
                stall_cnt <= '0;
                if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            end else begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign TIMEOUT_CNT = timeout_cnt;
`else
    assign timeout_hit = 1'b0;
    assign TIMEOUT_CNT = '0;
`endif

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state      <= IDLE;
            last_grant <= 3'(N - 1);
            grant_id   <= '0;
            out_write  <= 1'b0;
            out_data   <= '0;
        end else begin
            out_write <= pop;
            if (pop) out_data <= sel_data;
            case (state)
                IDLE: begin
                    if (hit) begin
                        grant_id   <= winner;
                        last_grant <= winner;
                        state      <= LOCK;
                    end
                end
                LOCK: begin
                    // Only a type-1 word keeps the frame open.
                    if (pop && sel_data[27:24] != 4'h1) state <= IDLE;
                    else if (timeout_hit)               state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign OUT_WRITE = out_write;
    assign OUT_DATA  = out_data;
    assign GRANT_ID  = grant_id;
    assign BUSY      = (state == LOCK);

endmodule

// File: tb/tb_timestamp_arbiter.sv
// Self-checking bench for timestamp_arbiter: FIFO-source models, pop monitor and expected-output scoreboard.
module tb_timestamp_arbiter;

    localparam int unsigned N          = 4;
    localparam int unsigned TB_TIMEOUT = 4;

    logic            BUS_CLK = 1'b0;
    logic            BUS_RST;
    logic [N-1:0]    ENABLE_MASK;
    logic [N-1:0]    IN_EMPTY;
    logic [32*N-1:0] IN_DATA;
    logic [N-1:0]    IN_READ;
    logic            OUT_FULL;
    logic            OUT_WRITE;
    logic [31:0]     OUT_DATA;
    logic [2:0]      GRANT_ID;
    logic            BUSY;
    logic [7:0]      TIMEOUT_CNT;

    timestamp_arbiter #(.N(N), .TIMEOUT(TB_TIMEOUT)) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .ENABLE_MASK(ENABLE_MASK),
        .IN_EMPTY(IN_EMPTY), .IN_DATA(IN_DATA), .IN_READ(IN_READ),
        .OUT_FULL(OUT_FULL), .OUT_WRITE(OUT_WRITE), .OUT_DATA(OUT_DATA),
        .GRANT_ID(GRANT_ID), .BUSY(BUSY), .TIMEOUT_CNT(TIMEOUT_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    logic [31:0] src_q [N][$];
    logic [31:0] exp_q [$];
    int          pop_cyc [$];
    int          pop_src [$];
    int          cyc  = 0;
    int          nerr = 0;
    int          nchk = 0;

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            IN_EMPTY[i] = (src_q[i].size() == 0);
            IN_DATA[i*32 +: 32] = (src_q[i].size() != 0) ? src_q[i][0] : 32'h0;
        end
    endtask

    // Source FIFO model and output scoreboard, evaluated just after each rising edge.
    always @(posedge BUS_CLK) begin
        logic [N-1:0] rd;
        logic [31:0]  w;
        logic [31:0]  e;
        logic         wr_exp;
        rd = IN_READ;
        w = '0;
        wr_exp = 1'b0;
        #1;
        cyc++;
        nchk++;
        if (!$onehot0(rd)) begin
            nerr++; $display("FAIL in_read_onehot: got %b, required at most one bit", rd);
        end
        for (int i = 0; i < N; i++) begin
            if (rd[i]) begin
                if (src_q[i].size() == 0) begin
                    nerr++; $display("FAIL pop_empty: source %0d popped while empty", i);
                end else begin
                    w = src_q[i].pop_front();
                    wr_exp = 1'b1;
                    pop_cyc.push_back(cyc);
                    pop_src.push_back(i);
                end
            end
        end
        refresh();
        nchk++;
        if (OUT_WRITE !== wr_exp) begin
            nerr++; $display("FAIL out_write: got %b, required %b (cycle %0d)", OUT_WRITE, wr_exp, cyc);
        end
        if (wr_exp) begin
            nchk++;
            if (OUT_DATA !== w) begin
                nerr++; $display("FAIL out_data_latency: got %h, required %h", OUT_DATA, w);
            end
            nchk++;
            if (exp_q.size() == 0) begin
                nerr++; $display("FAIL out_order: got unexpected word %h, required none", OUT_DATA);
            end else begin
                e = exp_q.pop_front();
                if (OUT_DATA !== e) begin
                    nerr++; $display("FAIL out_order: got %h, required %h", OUT_DATA, e);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge BUS_CLK);
            #2;
        end
    endtask

    task automatic push(input int s, input logic [31:0] w);
        src_q[s].push_back(w);
        refresh();
    endtask

    task automatic do_reset();
        BUS_RST = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        refresh();
        tick(2);
        BUS_RST = 1'b0;
        pop_cyc.delete();
        pop_src.delete();
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while (exp_q.size() != 0 && k < maxc) begin
            tick();
            k++;
        end
        nchk++;
        if (exp_q.size() != 0) begin
            nerr++; $display("FAIL drain_timeout: got %0d words outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic wait_pops(input int n, input int maxc);
        int k = 0;
        while (pop_cyc.size() < n && k < maxc) begin
            tick();
            k++;
        end
        nchk++;
        if (pop_cyc.size() < n) begin
            nerr++; $display("FAIL wait_pops: got %0d pops, required %0d", pop_cyc.size(), n);
        end
    endtask

    task automatic test_reset();
        BUS_RST = 1'b1;
        tick(2);
        nchk++;
        if (GRANT_ID !== 3'd0 || BUSY !== 1'b0 || OUT_WRITE !== 1'b0 || OUT_DATA !== 32'h0 || TIMEOUT_CNT !== 8'h0) begin
            nerr++; $display("FAIL reset_state: got grant=%0d busy=%b wr=%b data=%h tcnt=%0d, required all 0",
                             GRANT_ID, BUSY, OUT_WRITE, OUT_DATA, TIMEOUT_CNT);
        end
        push(0, 32'h11000001);
        tick(2);
        nchk++;
        if (IN_READ !== '0 || BUSY !== 1'b0) begin
            nerr++; $display("FAIL reset_hold: got in_read=%b busy=%b, required 0 0", IN_READ, BUSY);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        exp_q.push_back(32'h11000001);
        exp_q.push_back(32'h12000002);
        push(0, 32'h11000001);
        push(0, 32'h12000002);
        drain(20);
        nchk++;
        if (pop_cyc.size() != 2) begin
            nerr++; $display("FAIL single_pops: got %0d pops, required 2", pop_cyc.size());
        end else if (pop_cyc[1] - pop_cyc[0] != 1 || pop_src[0] != 0 || pop_src[1] != 0) begin
            nerr++; $display("FAIL single_pops: got gap %0d src %0d,%0d, required gap 1 src 0,0",
                             pop_cyc[1] - pop_cyc[0], pop_src[0], pop_src[1]);
        end
        nchk++;
        if (BUSY !== 1'b0 || GRANT_ID !== 3'd0) begin
            nerr++; $display("FAIL single_idle: got busy=%b grant=%0d, required 0 0", BUSY, GRANT_ID);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int s = 0; s < N; s++) begin
            exp_q.push_back({8'h11, 8'h00, 8'(s), 8'h01});
            exp_q.push_back({8'h12, 8'h00, 8'(s), 8'h02});
        end
        for (int s = 0; s < N; s++) begin
            src_q[s].push_back({8'h11, 8'h00, 8'(s), 8'h01});
            src_q[s].push_back({8'h12, 8'h00, 8'(s), 8'h02});
        end
        refresh();
        drain(80);
        nchk++;
        if (pop_cyc.size() != 2 * N) begin
            nerr++; $display("FAIL rr_pops: got %0d pops, required %0d", pop_cyc.size(), 2 * N);
        end else begin
            for (int j = 0; j < 2 * N; j++) begin
                nchk++;
                if (pop_src[j] != j / 2) begin
                    nerr++; $display("FAIL rr_src: pop %0d got source %0d, required %0d", j, pop_src[j], j / 2);
                end
                if (j > 0) begin
                    nchk++;
                    if (pop_cyc[j] - pop_cyc[j-1] != ((j % 2 == 1) ? 1 : 2)) begin
                        nerr++; $display("FAIL rr_gap: pop %0d got gap %0d, required %0d",
                                         j, pop_cyc[j] - pop_cyc[j-1], (j % 2 == 1) ? 1 : 2);
                    end
                end
            end
        end
    endtask

    task automatic test_stall_empty();
        do_reset();
        exp_q.push_back(32'h11000005);
        exp_q.push_back(32'h12000006);
        exp_q.push_back(32'h11000007);
        exp_q.push_back(32'h12000008);
        src_q[1].push_back(32'h11000005);
        src_q[2].push_back(32'h11000007);
        src_q[2].push_back(32'h12000008);
        refresh();
        tick(8);
        nchk++;
        if (BUSY !== 1'b1 || GRANT_ID !== 3'd1 || pop_cyc.size() != 1) begin
            nerr++; $display("FAIL empty_hold: got busy=%b grant=%0d pops=%0d, required 1 1 1",
                             BUSY, GRANT_ID, pop_cyc.size());
        end
        push(1, 32'h12000006);
        drain(30);
        nchk++;
        if (pop_src.size() != 4 || pop_src[1] != 1 || pop_src[2] != 2) begin
            nerr++; $display("FAIL empty_order: got %0d pops, required 4 with sources 1,1,2,2", pop_src.size());
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        exp_q.push_back(32'h11000010);
        exp_q.push_back(32'h12000011);
        push(0, 32'h11000010);
        push(0, 32'h12000011);
        wait_pops(1, 20);
        OUT_FULL = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            nchk++;
            if (BUSY !== 1'b1 || IN_READ !== '0 || pop_cyc.size() != 1) begin
                nerr++; $display("FAIL full_stall: cycle %0d got busy=%b in_read=%b pops=%0d, required 1 0 1",
                                 k, BUSY, IN_READ, pop_cyc.size());
            end
        end
        OUT_FULL = 1'b0;
        drain(10);
        nchk++;
        if (pop_cyc.size() != 2) begin
            nerr++; $display("FAIL full_resume: got %0d pops, required 2", pop_cyc.size());
        end else if (pop_cyc[1] - pop_cyc[0] != 11) begin
            nerr++; $display("FAIL full_resume: got gap %0d, required 11", pop_cyc[1] - pop_cyc[0]);
        end
    endtask

    task automatic test_mask();
        do_reset();
        ENABLE_MASK = 4'b1110;
        exp_q.push_back(32'h11000040);
        exp_q.push_back(32'h12000041);
        push(0, 32'h11000040);
        push(0, 32'h12000041);
        tick(5);
        nchk++;
        if (BUSY !== 1'b0 || IN_READ !== '0 || pop_cyc.size() != 0) begin
            nerr++; $display("FAIL mask_idle: got busy=%b in_read=%b pops=%0d, required 0 0 0",
                             BUSY, IN_READ, pop_cyc.size());
        end
        ENABLE_MASK = '1;
        wait_pops(1, 10);
        ENABLE_MASK = 4'b1110;
        drain(10);
        nchk++;
        if (pop_cyc.size() != 2 || BUSY !== 1'b0) begin
            nerr++; $display("FAIL mask_frame: got pops=%0d busy=%b, required 2 0", pop_cyc.size(), BUSY);
        end
        ENABLE_MASK = '1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        exp_q.push_back(32'h11000020);
        push(2, 32'h11000020);
        push(2, 32'h12000021);
        wait_pops(1, 20);
        BUS_RST = 1'b1;
        #1;
        nchk++;
        if (IN_READ !== '0) begin
            nerr++; $display("FAIL rst_in_read: got %b, required 0", IN_READ);
        end
        tick();
        nchk++;
        if (OUT_WRITE !== 1'b0 || GRANT_ID !== 3'd0 || BUSY !== 1'b0) begin
            nerr++; $display("FAIL rst_mid: got wr=%b grant=%0d busy=%b, required 0 0 0", OUT_WRITE, GRANT_ID, BUSY);
        end
        BUS_RST = 1'b0;
        pop_cyc.delete();
        pop_src.delete();
        exp_q.push_back(32'h11000030);
        exp_q.push_back(32'h12000031);
        exp_q.push_back(32'h12000021);
        push(0, 32'h11000030);
        push(0, 32'h12000031);
        drain(30);
        nchk++;
        if (pop_src.size() != 3 || pop_src[0] != 0 || pop_src[2] != 2) begin
            nerr++; $display("FAIL rst_restart: got %0d pops, required 3 with sources 0,0,2", pop_src.size());
        end
    endtask

`ifdef TIMESTAMP_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        exp_q.push_back(32'h11000050);
        exp_q.push_back(32'h13000051);
        src_q[0].push_back(32'h11000050);
        src_q[1].push_back(32'h13000051);
        refresh();
        drain(40);
        nchk++;
        if (TIMEOUT_CNT !== 8'd1 || GRANT_ID !== 3'd1) begin
            nerr++; $display("FAIL timeout_release: got tcnt=%0d grant=%0d, required 1 1", TIMEOUT_CNT, GRANT_ID);
        end
        nchk++;
        if (pop_cyc.size() != 2) begin
            nerr++; $display("FAIL timeout_gap: got %0d pops, required 2", pop_cyc.size());
        end else if (pop_cyc[1] - pop_cyc[0] != 6) begin
            nerr++; $display("FAIL timeout_gap: got gap %0d, required 6", pop_cyc[1] - pop_cyc[0]);
        end
    endtask
`else
    task automatic test_timeout();
        do_reset();
        exp_q.push_back(32'h11000050);
        src_q[0].push_back(32'h11000050);
        src_q[1].push_back(32'h13000051);
        refresh();
        drain(10);
        tick(20);
        nchk++;
        if (BUSY !== 1'b1 || GRANT_ID !== 3'd0 || TIMEOUT_CNT !== 8'd0 || pop_cyc.size() != 1) begin
            nerr++; $display("FAIL no_timeout_hold: got busy=%b grant=%0d tcnt=%0d pops=%0d, required 1 0 0 1",
                             BUSY, GRANT_ID, TIMEOUT_CNT, pop_cyc.size());
        end
        exp_q.push_back(32'h12000052);
        exp_q.push_back(32'h13000051);
        push(0, 32'h12000052);
        drain(30);
        nchk++;
        if (pop_src.size() != 3 || pop_src[1] != 0 || pop_src[2] != 1) begin
            nerr++; $display("FAIL no_timeout_order: got %0d pops, required 3 with sources 0,0,1", pop_src.size());
        end
    endtask
`endif

    initial begin
        #200000;
        nerr++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        BUS_RST     = 1'b1;
        ENABLE_MASK = '1;
        OUT_FULL    = 1'b0;
        refresh();
        test_reset();
        test_single_frame();
        test_round_robin();
        test_stall_empty();
        test_full_stall();
        test_mask();
        test_reset_mid();
        test_timeout();
        tick(2);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
